pipeline_hazard_ctrl: RTL

Hazard and redirect controller for the 5-stage MIPS pipeline. It has no forwarding paths. It keeps a shadow scoreboard of destination registers in flight in EX, MEM and WB, and stalls PC and IF/ID while the instruction in ID reads a pending register. It flushes the younger stages when a taken branch resolves in MEM, and counts stall and flush events for the bench.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/hazard_cmp.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: types and constants shared by the pipeline hazard controller.
//   hz_state_t : controller FSM state (RUN, STALL, FLUSH)
//   sb_slot_t  : one scoreboard entry, {valid, dest[4:0]}
//   REG_ZERO   : architectural zero register, never a real dependency
package mips_pkg;

   typedef enum logic [1:0] {RUN, STALL, FLUSH} hz_state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
   } sb_slot_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // True when a valid in-flight slot will write register r.
   function automatic logic slot_match(input sb_slot_t s, input logic [4:0] r);
      return s.valid && (s.dest == r);
   endfunction

endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: checks one ID source register against the EX, MEM and WB
// scoreboard slots.
//   i_src      : source register number read by the ID instruction
//   i_uses     : the ID instruction actually reads i_src
//   i_ex_slot  : EX slot  {valid, dest}
//   i_mem_slot : MEM slot {valid, dest}
//   i_wb_slot  : WB slot  {valid, dest}
//   o_hit      : i_src is pending in at least one slot
module hazard_cmp
   import mips_pkg::*;
(
   input  logic [4:0] i_src,
   input  logic       i_uses,
   input  logic [5:0] i_ex_slot,
   input  logic [5:0] i_mem_slot,
   input  logic [5:0] i_wb_slot,
   output logic       o_hit
);

   sb_slot_t w_ex;
   sb_slot_t w_mem;
   sb_slot_t w_wb;

   assign w_ex  = sb_slot_t'(i_ex_slot);
   assign w_mem = sb_slot_t'(i_mem_slot);
   assign w_wb  = sb_slot_t'(i_wb_slot);

   // WB counts as pending: the register file does not forward a same-cycle write.
   assign o_hit = i_uses && (i_src != REG_ZERO) &&
                  (slot_match(w_ex, i_src) || slot_match(w_mem, i_src) ||
                   slot_match(w_wb, i_src));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/redirect controller for a 5-stage MIPS pipeline
// without forwarding. A shadow scoreboard tracks destinations in EX/MEM/WB.
//   clk, reset          : clock, synchronous active-low reset
//   id_rs, id_rt        : source registers of the ID instruction
//   id_uses_rs/_rt      : ID instruction reads rs / rt
//   id_reg_write,id_dest: ID instruction writes id_dest
//   mem_pc_src          : taken branch resolved in MEM
//   pc_write,if_id_write: PC / IF-ID load enables
//   *_flush             : bubble injection per pipeline register
//   stall_cycles        : count of data-stall cycles
//   flush_events        : count of accepted redirects
module pipeline_hazard_ctrl
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_reg_write,
   input  logic [4:0]       id_dest,
   input  logic             mem_pc_src,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   hz_state_t        r_state;
   hz_state_t        w_next_state;
   sb_slot_t         r_ex_slot;
   sb_slot_t         r_mem_slot;
   sb_slot_t         r_wb_slot;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_rs_hit;
   logic w_rt_hit;
   logic w_hz;
   logic w_redirect;
   logic w_stall;

   hazard_cmp u_cmp_rs (
      .i_src      (id_rs),
      .i_uses     (id_uses_rs),
      .i_ex_slot  (r_ex_slot),
      .i_mem_slot (r_mem_slot),
      .i_wb_slot  (r_wb_slot),
      .o_hit      (w_rs_hit)
   );

   hazard_cmp u_cmp_rt (
      .i_src      (id_rt),
      .i_uses     (id_uses_rt),
      .i_ex_slot  (r_ex_slot),
      .i_mem_slot (r_mem_slot),
      .i_wb_slot  (r_wb_slot),
      .o_hit      (w_rt_hit)
   );

   assign w_hz = w_rs_hit || w_rt_hit;
   // In FLUSH, EX/MEM holds a squashed bubble, so a held mem_pc_src is stale.
   assign w_redirect = mem_pc_src && (r_state != FLUSH);
   // A redirect overrides a stall: the stalled ID instruction is wrong-path.
   assign w_stall = w_hz && !w_redirect;

   // Pipeline control outputs, forced safe while reset is low.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      if (!reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (w_redirect) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (w_hz) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end else begin
         pc_write    = 1'b1;
         if_id_write = 1'b1;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         RUN: begin
            if (mem_pc_src)  w_next_state = FLUSH;
            else if (w_hz)   w_next_state = STALL;
            else             w_next_state = RUN;
         end
         STALL: begin
            if (mem_pc_src)  w_next_state = FLUSH;
            else if (!w_hz)  w_next_state = RUN;
            else             w_next_state = STALL;
         end
         FLUSH:   w_next_state = RUN;
         default: w_next_state = RUN;
      endcase
   end

   // State, scoreboard shift and event counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= RUN;
         r_ex_slot   <= '0;
         r_mem_slot  <= '0;
         r_wb_slot   <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         if (id_ex_flush) begin
            r_ex_slot <= '0;
         end else begin
            r_ex_slot.valid <= id_reg_write && (id_dest != REG_ZERO);
            r_ex_slot.dest  <= id_dest;
         end
         r_mem_slot  <= ex_mem_flush ? sb_slot_t'(6'd0) : r_ex_slot;
         r_wb_slot   <= r_mem_slot;
         r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, w_stall};
         r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, w_redirect};
      end
   end

   assign stall_cycles = r_stall_cnt;
   assign flush_events = r_flush_cnt;

endmodule
